// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, status bit
// positions, command FSM states and read-data sources.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_REMS = 8'h90;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'h20;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_WEL  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DATA_IN,
    ST_DATA_OUT,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    SRC_STATUS,
    SRC_MEM,
    SRC_ID
  } src_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic wel);
    logic [7:0] s;
    s = '0;
    s[STAT_BUSY] = busy;
    s[STAT_WEL]  = wel;
    return s;
  endfunction

endpackage

// File: rtl/spi_flash_responder_shifter.sv
// SPI mode-0 slave front end: pin synchronizers, edge detection, bit counting,
// MOSI byte assembly and MISO shifting of the byte supplied by the command logic.
module spi_slave_shifter (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic [5:0] bit_cnt
);

  logic [2:0] sck_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_idx;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic       sck_rise;
  logic       sck_fall;
  logic       cs_act;

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];
  assign cs_act   = ~cs_sync[1];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      cs_sync   <= {cs_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bit_idx    <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_fall) begin
        bit_idx <= '0;
        bit_cnt <= '0;
      end else if (cs_act && sck_rise) begin
        rx_sr   <= {rx_sr[6:0], mosi_sync[1]};
        bit_idx <= bit_idx + 1'b1;
        if (bit_cnt != '1)
          bit_cnt <= bit_cnt + 1'b1;
        if (bit_idx == 3'd7) begin
          rx_byte    <= {rx_sr[6:0], mosi_sync[1]};
          byte_valid <= 1'b1;
        end
      end
    end
  end

  // A fall with bit_idx back at 0 follows the last bit of a byte, so the next
  // byte's MSB is presented there, ahead of that byte's first rising edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      miso  <= 1'b1;
      tx_sr <= '1;
    end else if (!cs_act) begin
      miso  <= 1'b1;
      tx_sr <= '1;
    end else if (sck_fall) begin
      if (bit_idx == 3'd0) begin
        miso  <= tx_data[7];
        tx_sr <= {tx_data[6:0], 1'b1};
      end else begin
        miso  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// W25Q-style SPI NOR-flash emulator: command FSM, WEL/BUSY status, busy timer,
// sector-erase sweep and a small RAM-backed array behind spi_slave_shifter.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int unsigned MEM_AW       = 8,
  parameter logic [7:0]  MFR_ID       = 8'hEF,
  parameter logic [7:0]  DEV_ID       = 8'h16,
  parameter int unsigned ERASE_CYCLES = 20000,
  parameter int unsigned PROG_CYCLES  = 2000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       flash_clk,
  input  logic       flash_cs,
  input  logic       flash_datain,
  output logic       flash_dataout,
  output logic       busy_o,
  output logic       wel_o,
  output logic [7:0] last_cmd_o
);

  localparam int unsigned        MEM_SIZE  = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0]  PAGE_MASK = (MEM_AW > 8) ? MEM_AW'(255) : '1;

  logic [7:0]        mem [MEM_SIZE];
  logic              cs_fall;
  logic              cs_rise;
  logic              byte_valid;
  logic [7:0]        rx_byte;
  logic [5:0]        bit_cnt;

  state_t            state;
  src_t              src;
  logic [7:0]        cmd;
  logic [7:0]        tx_data;
  logic [7:0]        last_cmd;
  logic [1:0]        addr_bytes;
  logic [MEM_AW-1:0] addr_sr;
  logic [MEM_AW-1:0] addr_nxt;
  logic [MEM_AW-1:0] ptr;
  logic [MEM_AW-1:0] erase_ptr;
  logic              erasing;
  logic              busy;
  logic              wel;
  logic              pp_wrote;
  logic              id_next;
  logic [31:0]       busy_cnt;

  logic              mem_we;
  logic [MEM_AW-1:0] mem_wa;
  logic [7:0]        mem_wd;

  spi_slave_shifter u_shifter (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .sck        (flash_clk),
    .cs_n       (flash_cs),
    .mosi       (flash_datain),
    .tx_data    (tx_data),
    .miso       (flash_dataout),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .bit_cnt    (bit_cnt)
  );

  assign addr_nxt   = MEM_AW'({addr_sr, rx_byte});
  assign busy_o     = busy;
  assign wel_o      = wel;
  assign last_cmd_o = last_cmd;

  function automatic logic [MEM_AW-1:0] page_inc(input logic [MEM_AW-1:0] p);
    return (p & ~PAGE_MASK) | ((p + 1'b1) & PAGE_MASK);
  endfunction

  // PP only runs while not busy, so it never contends with the erase sweep.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = erase_ptr;
    mem_wd = 8'hFF;
    if (erasing) begin
      mem_we = 1'b1;
    end else if (state == ST_DATA_IN && cmd == CMD_PP && byte_valid) begin
      mem_we = 1'b1;
      mem_wa = ptr;
      mem_wd = mem[ptr] & rx_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      src        <= SRC_STATUS;
      cmd        <= '0;
      tx_data    <= '1;
      last_cmd   <= '0;
      addr_bytes <= '0;
      addr_sr    <= '0;
      ptr        <= '0;
      erase_ptr  <= '0;
      erasing    <= 1'b0;
      busy       <= 1'b0;
      wel        <= 1'b0;
      pp_wrote   <= 1'b0;
      id_next    <= 1'b0;
      busy_cnt   <= '0;
    end else begin
      if (erasing) begin
        erase_ptr <= erase_ptr + 1'b1;
        if (erase_ptr == '1)
          erasing <= 1'b0;
      end
      if (busy) begin
        if (busy_cnt == '0) begin
          busy <= 1'b0;
          wel  <= 1'b0;
        end else begin
          busy_cnt <= busy_cnt - 1'b1;
        end
      end

      if (cs_rise) begin
        state <= ST_IDLE;
        if (state != ST_IDLE && bit_cnt >= 6'd8)
          last_cmd <= cmd;
        if (state == ST_DATA_IN) begin
          case (cmd)
            CMD_WREN: if (bit_cnt == 6'd8) wel <= 1'b1;
            CMD_WRDI: if (bit_cnt == 6'd8) wel <= 1'b0;
            CMD_PP: begin
              if (pp_wrote) begin
                busy     <= 1'b1;
                busy_cnt <= 32'(PROG_CYCLES - 1);
              end
            end
            CMD_SE: begin
              if (wel && bit_cnt == 6'd32) begin
                busy      <= 1'b1;
                busy_cnt  <= 32'(ERASE_CYCLES - 1);
                erasing   <= 1'b1;
                erase_ptr <= '0;
              end
            end
            default: ;
          endcase
        end
      end else if (cs_fall) begin
        state      <= ST_OPCODE;
        tx_data    <= '1;
        addr_bytes <= '0;
        pp_wrote   <= 1'b0;
      end else if (byte_valid) begin
        case (state)
          ST_OPCODE: begin
            cmd <= rx_byte;
            if (busy && rx_byte != CMD_RDSR) begin
              state <= ST_IGNORE;
            end else begin
              case (rx_byte)
                CMD_RDSR: begin
                  state   <= ST_DATA_OUT;
                  src     <= SRC_STATUS;
                  tx_data <= status_byte(busy, wel);
                end
                CMD_WREN, CMD_WRDI:          state <= ST_DATA_IN;
                CMD_READ, CMD_REMS, CMD_SE:  state <= ST_ADDR;
                CMD_PP:                      state <= wel ? ST_ADDR : ST_IGNORE;
                default:                     state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            addr_sr    <= addr_nxt;
            addr_bytes <= addr_bytes + 1'b1;
            if (addr_bytes == 2'd2) begin
              case (cmd)
                CMD_READ: begin
                  state   <= ST_DATA_OUT;
                  src     <= SRC_MEM;
                  tx_data <= mem[addr_nxt];
                  ptr     <= addr_nxt + 1'b1;
                end
                CMD_REMS: begin
                  state   <= ST_DATA_OUT;
                  src     <= SRC_ID;
                  tx_data <= addr_nxt[0] ? DEV_ID : MFR_ID;
                  id_next <= ~addr_nxt[0];
                end
                CMD_PP: begin
                  state <= ST_DATA_IN;
                  ptr   <= addr_nxt;
                end
                default: state <= ST_DATA_IN;
              endcase
            end
          end
          ST_DATA_OUT: begin
            case (src)
              SRC_STATUS: tx_data <= status_byte(busy, wel);
              SRC_MEM: begin
                tx_data <= mem[ptr];
                ptr     <= ptr + 1'b1;
              end
              default: begin
                tx_data <= id_next ? DEV_ID : MFR_ID;
                id_next <= ~id_next;
              end
            endcase
          end
          ST_DATA_IN: begin
            if (cmd == CMD_PP) begin
              ptr      <= page_inc(ptr);
              pp_wrote <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
